// File: rtl/dest_reg_tracker_pkg.sv
// Shared CPU package: register-address width, x0 constant and the
// per-stage destination-tracking entry {rd, we, ld}.
package dest_reg_tracker_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
      logic                  ld;
   } stage_entry_t;

   localparam stage_entry_t BUBBLE = '{rd: '0, we: 1'b0, ld: 1'b0};

endpackage

// File: rtl/dest_stage_reg.sv
// One pipeline-stage destination entry. Priority: hold > bubble > load.
module dest_stage_reg
   import dest_reg_tracker_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         hold,
   input  logic         bubble,
   input  stage_entry_t d,
   output stage_entry_t q
);

   // Entry register; reset and bubble both leave a harmless {0,0,0}.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= BUBBLE;
      end else if (hold) begin
         q <= q;
      end else if (bubble) begin
         q <= BUBBLE;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/dest_reg_tracker.sv
// Destination-register tracker for the EX/MEM/WB stages with load-use
// stall detection. Optional feature macro: LOAD_USE_STALL_EN (stall
// detection and stall counter); when undefined the stall output and the
// counter are tied to zero and software fills load delay slots.
module dest_reg_tracker #(
   parameter int REG_ADDR_W = dest_reg_tracker_pkg::REG_ADDR_W,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_addr1,
   input  logic [REG_ADDR_W-1:0] id_addr2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_write_en,
   input  logic                  id_is_load,
   input  logic                  mem_busy,
   input  logic                  flush,
   output logic [REG_ADDR_W-1:0] ex_addr,
   output logic [REG_ADDR_W-1:0] mem_addr,
   output logic [REG_ADDR_W-1:0] wb_addr,
   output logic                  ex_write_en,
   output logic                  mem_write_en,
   output logic                  wb_write_en,
   output logic                  load_use_stall,
   output logic [CNT_W-1:0]      stall_count
);

   import dest_reg_tracker_pkg::*;

   stage_entry_t id_entry;
   stage_entry_t ex_q;
   stage_entry_t mem_q;
   stage_entry_t wb_q;

   // Decode-stage entry; non-writing or x0-writing instructions become bubbles.
   always_comb begin
      id_entry    = BUBBLE;
      id_entry.we = id_valid & id_write_en & (id_rd != X0_ADDR);
      id_entry.ld = id_valid & id_is_load & id_entry.we;
      if (id_entry.we) begin
         id_entry.rd = id_rd;
      end
   end

   dest_stage_reg u_ex (
      .clk     (clk),
      .reset_n (reset_n),
      .hold    (mem_busy),
      .bubble  (flush | load_use_stall),
      .d       (id_entry),
      .q       (ex_q)
   );

   dest_stage_reg u_mem (
      .clk     (clk),
      .reset_n (reset_n),
      .hold    (mem_busy),
      .bubble  (1'b0),
      .d       (ex_q),
      .q       (mem_q)
   );

   dest_stage_reg u_wb (
      .clk     (clk),
      .reset_n (reset_n),
      .hold    (mem_busy),
      .bubble  (1'b0),
      .d       (mem_q),
      .q       (wb_q)
   );

   assign ex_addr      = ex_q.rd;
   assign mem_addr     = mem_q.rd;
   assign wb_addr      = wb_q.rd;
   assign ex_write_en  = ex_q.we;
   assign mem_write_en = mem_q.we;
   assign wb_write_en  = wb_q.we;

`ifdef LOAD_USE_STALL_EN
   // A load in EX feeding either decode source needs one bubble; a flush
   // kills the decode instruction so no stall is needed.
   assign load_use_stall = ex_q.ld & ex_q.we & id_valid &
                           ((id_addr1 == ex_q.rd) | (id_addr2 == ex_q.rd)) & ~flush;

   // Saturating stall-cycle counter; frozen while memory is busy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_count <= '0;
      end else if (load_use_stall && !mem_busy && (stall_count != '1)) begin
         stall_count <= stall_count + 1'b1;
      end
   end

   logic unused_ld;
   assign unused_ld = mem_q.ld ^ wb_q.ld;
`else
   assign load_use_stall = 1'b0;
   assign stall_count    = '0;

   logic unused_ld;
   assign unused_ld = ^{ex_q.ld, mem_q.ld, wb_q.ld, id_addr1, id_addr2};
`endif

endmodule

// File: doc/dest_reg_tracker.md
DEST_REG_TRACKER -- requirements
Module: dest_reg_tracker

Interface
REQ-001 Parameter: REG_ADDR_W, default 5; register-address width.
REQ-002 Parameter: CNT_W, default 16; stall-counter width.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 ID_VALID  input  1  decode-stage instruction valid.
REQ-006 ID_ADDR1, ID_ADDR2  input  5 each  decode-stage source register addresses.
REQ-007 ID_RD  input  5  decode-stage destination register.
REQ-008 ID_WRITE_EN  input  1  decode-stage instruction writes the register file.
REQ-009 ID_IS_LOAD  input  1  decode-stage instruction is a load.
REQ-010 MEM_BUSY  input  1  data memory not ready; freezes the tracker.
REQ-011 FLUSH  input  1  taken branch/jump resolved in EX; kills the decode instruction.
REQ-012 EX_ADDR, MEM_ADDR, WB_ADDR  output  5 each  destination register held in EX, MEM and WB.
REQ-013 EX_WRITE_EN, MEM_WRITE_EN, WB_WRITE_EN  output  1 each  write enable held in each stage; feeds the EX forwarding unit.
REQ-014 LOAD_USE_STALL  output  1  hold PC/IF/ID this cycle; insert a bubble into EX.
REQ-015 STALL_COUNT  output  CNT_W  saturating count of load-use stall cycles.

Function
REQ-016 Three stage entries (EX, MEM, WB); each entry is {rd, we, ld}; a bubble is {0,0,0}.
REQ-017 Captured we SHALL be ID_VALID & ID_WRITE_EN & (ID_RD != 0); writes to x0 are never tracked.
REQ-018 Captured ld SHALL be ID_VALID & ID_IS_LOAD & captured we.
REQ-019 LOAD_USE_STALL (combinational) = EX.ld & EX.we & ID_VALID & (ID_ADDR1 == EX.rd | ID_ADDR2 == EX.rd) & ~FLUSH.
REQ-020 Update priority per edge: MEM_BUSY > FLUSH > LOAD_USE_STALL > normal advance.
REQ-021 MEM_BUSY=1: all three entries and STALL_COUNT hold; LOAD_USE_STALL still evaluated combinationally.
REQ-022 FLUSH=1, MEM_BUSY=0: EX<=bubble, MEM<=EX, WB<=MEM.
REQ-023 LOAD_USE_STALL=1, MEM_BUSY=0: EX<=bubble, MEM<=EX, WB<=MEM; decode inputs are not captured.
REQ-024 Normal advance: EX<=captured ID, MEM<=EX, WB<=MEM.
REQ-025 One load-use hazard SHALL produce exactly one stall cycle; the dependent instruction then forwards from WB.
REQ-026 STALL_COUNT increments by 1 on each edge where LOAD_USE_STALL=1 and MEM_BUSY=0, and saturates at all-ones.
REQ-027 Outputs EX_*/MEM_*/WB_* are driven directly from registers and have no combinational path from the inputs.

Reset
REQ-028 RESET_N=0 SHALL asynchronously force all entries to bubble and STALL_COUNT to 0; all *_ADDR and *_WRITE_EN outputs SHALL read 0.
REQ-029 Reset asserted mid-stall or mid-busy SHALL discard all in-flight entries; the first edge after release SHALL perform a normal advance.

Configuration
REQ-030 Macro LOAD_USE_STALL_EN defined: behaviour exactly as REQ-019, REQ-023, REQ-025 and REQ-026.
REQ-031 LOAD_USE_STALL_EN undefined: LOAD_USE_STALL tied to 0, STALL_COUNT tied to 0, counter logic removed; software schedules load delay slots.

Structure
REQ-032 The shared CPU package SHALL hold REG_ADDR_W, the x0 address constant and the stage-entry typedef {rd, we, ld}.
REQ-033 One sub-module, dest_stage_reg (a single entry with hold/bubble/load controls), SHALL be instantiated three times.

Verification
REQ-034 ID rd=5'd11, we=1, no load, three clean edges -> EX, MEM, WB addresses show 11 on successive cycles; WB_WRITE_EN=1 on the 3rd cycle.
REQ-035 ID rd=5'd0, we=1 -> all *_WRITE_EN stay 0 throughout the pipe.
REQ-036 Load with rd=7 in EX; ID_ADDR2=7 -> LOAD_USE_STALL=1 for exactly one cycle; EX becomes bubble; STALL_COUNT=1; the next cycle shows MEM_ADDR=7 and LOAD_USE_STALL=0.
REQ-037 Same hazard with FLUSH=1 -> LOAD_USE_STALL=0; EX becomes bubble; STALL_COUNT unchanged.
REQ-038 MEM_BUSY=1 for 4 cycles with a load in EX and a dependent instruction in ID -> entries frozen and STALL_COUNT unchanged; after release, exactly one stall is counted.
REQ-039 RESET_N pulsed low between edges while MEM=rd 3 and WB=rd 9 -> all outputs read 0 immediately, without waiting for a clock edge.
